xcore_if_bim_sat: RTL

Parametrised bimodal branch-history table for the Xcore fetch-stage BPU. Holds 2^IDX_W saturating counters of CTR_W bits. Serves registered taken/not-taken predictions to the front end and applies saturating increment/decrement updates from commit. Adds a hardware initialisation sweep, a software-triggered clear, and an optional same-cycle write-to-read bypass.

---
 rtl/xcore_if_bim_sat.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/xcore_if_bim_sat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xcore_if_bim_sat                                                |
// | Brief    : Bimodal saturating-counter table with init sweep and SW clear;  |
// |            optional same-cycle update bypass via XCORE_BIM_BYPASS_EN.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module xcore_if_bim_sat #(
  parameter int IDX_W    = 10,
  parameter int CTR_W    = 2,
  parameter int INIT_VAL = 1
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst,
  input  logic             i_bim_clr,
  input  logic             i_bpu_req,
  input  logic [IDX_W-1:0] i_bpu_addr,
  input  logic             i_cmt_req,
  input  logic [IDX_W-1:0] i_cmt_addr,
  input  logic             i_cmt_taken,
  output logic             o_bim_ready,
  output logic             o_bim_vld,
  output logic [CTR_W-1:0] o_bim_bits,
  output logic             o_bim_taken
);

  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_MIN  = '0;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_VAL);
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [CTR_W-1:0] bits_q, bits_d;
  logic [CTR_W-1:0] mem_q [DEPTH];

  logic             w_lkp_acc;
  logic             w_upd_acc;
  logic [CTR_W-1:0] w_upd_old;
  logic [CTR_W-1:0] w_upd_new;
  logic [CTR_W-1:0] w_lkp_data;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_addr;
  logic [CTR_W-1:0] w_wr_data;

  assign w_lkp_acc = (state_q == ST_READY) && i_bpu_req;
  assign w_upd_acc = (state_q == ST_READY) && i_cmt_req && !i_bim_clr;

  assign w_upd_old = mem_q[i_cmt_addr];

  always_comb begin
    w_upd_new = w_upd_old;
    if (i_cmt_taken) begin
      if (w_upd_old != CTR_MAX) w_upd_new = w_upd_old + CTR_W'(1);
    end else begin
      if (w_upd_old != CTR_MIN) w_upd_new = w_upd_old - CTR_W'(1);
    end
  end

`ifdef XCORE_BIM_BYPASS_EN
  // Forward the counter being written this cycle to a colliding lookup.
  assign w_lkp_data = (w_upd_acc && (i_cmt_addr == i_bpu_addr)) ? w_upd_new
                                                                : mem_q[i_bpu_addr];
`else
  assign w_lkp_data = mem_q[i_bpu_addr];
`endif

  // The sweep owns the write port while initialising; commit owns it otherwise.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = i_cmt_addr;
    w_wr_data = w_upd_new;
    if (state_q == ST_INIT) begin
      w_wr_en   = 1'b1;
      w_wr_addr = idx_q;
      w_wr_data = CTR_INIT;
    end else if (w_upd_acc) begin
      w_wr_en   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_INIT: begin
        idx_d = idx_q + IDX_W'(1);
        if (i_bim_clr) begin
          idx_d = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (i_bim_clr) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    vld_d  = w_lkp_acc;
    bits_d = bits_q;
    if (w_lkp_acc) bits_d = w_lkp_data;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      bits_q  <= bits_d;
    end
  end

  // Counter storage carries no reset; the sweep defines its contents.
  always_ff @(posedge i_sys_clk) begin
    if (w_wr_en) mem_q[w_wr_addr] <= w_wr_data;
  end

  assign o_bim_ready = (state_q == ST_READY);
  assign o_bim_vld   = vld_q;
  assign o_bim_bits  = bits_q;
  assign o_bim_taken = bits_q[CTR_W-1];

endmodule
`default_nettype wire
